// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM input and reports it as a top/cmp pair
// (period-1, high cycles), i.e. the settings that would reproduce the wave.
`timescale 1ns/1ps
module pwm_capture #(
  parameter int W           = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic         pwm_in,
  output logic [W-1:0] top,
  output logic [W-1:0] cmp,
  output logic         valid,
  output logic         timeout,
  output logic         level
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_r;
  logic [SYNC_STAGES:0]   primed_r;
  logic                   s_d_r;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [W-1:0]           cnt_r;
  logic [W-1:0]           cnt_nxt_s;
  logic [W-1:0]           cnt_inc_s;
  logic [W-1:0]           hi_r;
  logic [W-1:0]           hi_nxt_s;
  logic [W-1:0]           top_nxt_s;
  logic [W-1:0]           cmp_nxt_s;
  logic                   valid_nxt_s;
  logic                   timeout_nxt_s;
  logic                   s_s;
  logic                   rise_s;
  logic                   fall_s;
  logic                   sat_s;
  logic                   primed_s;

  assign s_s      = sync_r[SYNC_STAGES-1];
  assign rise_s   = s_s & ~s_d_r;
  assign fall_s   = ~s_s & s_d_r;
  assign sat_s    = (cnt_r == CNT_MAX);
  // cnt holds (cycles since accepting rise) - 1, so the incremented value is the true count.
  assign cnt_inc_s = sat_s ? CNT_MAX : (cnt_r + CNT_ONE);
  // The sync chain resets to 0; IDLE must not mistake that for a real low after reset.
  assign primed_s = primed_r[SYNC_STAGES];

  // Input synchronizer, edge-detect delay and post-reset priming marker.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_r   <= '0;
      primed_r <= '0;
      s_d_r    <= 1'b0;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], pwm_in};
      primed_r <= {primed_r[SYNC_STAGES-1:0], 1'b1};
      s_d_r    <= s_s;
    end
  end

  // Next-state and next-output logic of the capture FSM.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    hi_nxt_s      = hi_r;
    top_nxt_s     = top;
    cmp_nxt_s     = cmp;
    valid_nxt_s   = 1'b0;
    timeout_nxt_s = timeout;
    if (!en) begin
      state_nxt_s   = IDLE;
      cnt_nxt_s     = CNT_ZERO;
      timeout_nxt_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (primed_s && !s_s) begin
            state_nxt_s = ARMED;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        ARMED: begin
          if (rise_s) begin
            state_nxt_s = HIGH;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = ARMED;
          end
        end
        HIGH: begin
          if (fall_s) begin
            state_nxt_s = LOW;
            hi_nxt_s    = cnt_inc_s;
            cnt_nxt_s   = cnt_inc_s;
          end else if (sat_s) begin
            state_nxt_s   = IDLE;
            timeout_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_inc_s;
          end
        end
        LOW: begin
          if (rise_s) begin
            state_nxt_s   = HIGH;
            top_nxt_s     = cnt_r;
            cmp_nxt_s     = hi_r;
            valid_nxt_s   = 1'b1;
            timeout_nxt_s = 1'b0;
            cnt_nxt_s     = CNT_ZERO;
          end else if (sat_s) begin
            state_nxt_s   = IDLE;
            timeout_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_inc_s;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      hi_r    <= CNT_ZERO;
      top     <= CNT_ZERO;
      cmp     <= CNT_ZERO;
      valid   <= 1'b0;
      timeout <= 1'b0;
      level   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      hi_r    <= hi_nxt_s;
      top     <= top_nxt_s;
      cmp     <= cmp_nxt_s;
      valid   <= valid_nxt_s;
      timeout <= timeout_nxt_s;
      level   <= s_s;
    end
  end

endmodule
